mem_access_ctrl: RTL and testbench

Memory access sequencer between the microprogrammed control unit and the external memory. It holds the MAR and MBR and runs one read or write per WMFC request. It drives the memory strobes and returns a one-cycle MFC pulse that releases the control unit's WMFC stall. Its control inputs come straight from the control-signal bus: MAR_in, rnw, WMFC and an MBR load strobe.

---
 rtl/mem_access_ctrl.sv | 81 ++++++++
 tb/tb_mem_access_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: holds MAR/MBR and runs one memory read or write per
// WMFC request, then returns a one-cycle MFC pulse to release the control unit.
module mem_access_ctrl #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int LATENCY = 2
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [DW-1:0] bus_in,
  input  logic          mar_in,
  input  logic          mbr_in,
  input  logic          rnw,
  input  logic          wmfc,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW-1:0] mbr,
  output logic          mfc,
  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]    state;
  logic [AW-1:0] mar;
  logic          op;
  logic [3:0]    cnt;

  // Register loads and the access request are only honoured in IDLE, so a
  // same-edge load plus request makes the access use the fresh MAR/MBR.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      mar   <= '0;
      mbr   <= '0;
      op    <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mar_in) mar <= bus_in[AW-1:0];
          if (mbr_in) mbr <= bus_in;
          if (wmfc) begin
            op    <= rnw;
            state <= ACCESS;
          end
        end
        ACCESS: begin
          cnt   <= CNT_INIT;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (op) mbr <= mem_rdata;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is decoded from registered state so no input reaches an output.
  assign mem_addr  = mar;
  assign mem_wdata = mbr;
  assign mem_en    = (state == ACCESS);
  assign mem_we    = (state == ACCESS) && !op;
  assign mfc       = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: one instance at LATENCY=2 and one at
// LATENCY=1, each with a small memory model that only drives valid read data when due.
module tb_mem_access_ctrl;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] bus_in;
  logic       mar_in, mbr_in, rnw;
  logic       wmfc_a, wmfc_b;
  logic [7:0] rdata_a, rdata_b;
  logic [7:0] mem_addr_a, mem_wdata_a, mbr_a;
  logic [7:0] mem_addr_b, mem_wdata_b, mbr_b;
  logic       mem_en_a, mem_we_a, mfc_a, busy_a;
  logic       mem_en_b, mem_we_b, mfc_b, busy_b;

  typedef struct {
    logic [7:0] addr;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] mbr;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  logic [7:0] mem_m [256];
  logic [7:0] mar_m, mbr_m;
  int cyc = 0;
  int en_cyc_a = 0, en_cyc_b = 0;
  int since_a = 0, since_b = 0;
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'h00;
  int errCount = 0;
  int checkCount = 0;

  mem_access_ctrl #(.AW(8), .DW(8), .LATENCY(2)) dut_a (
    .CLK(CLK), .reset(reset), .bus_in(bus_in), .mar_in(mar_in), .mbr_in(mbr_in),
    .rnw(rnw), .wmfc(wmfc_a), .mem_rdata(rdata_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_en(mem_en_a), .mem_we(mem_we_a), .mbr(mbr_a),
    .mfc(mfc_a), .busy(busy_a)
  );

  mem_access_ctrl #(.AW(8), .DW(8), .LATENCY(1)) dut_b (
    .CLK(CLK), .reset(reset), .bus_in(bus_in), .mar_in(mar_in), .mbr_in(mbr_in),
    .rnw(rnw), .wmfc(wmfc_b), .mem_rdata(rdata_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .mbr(mbr_b),
    .mfc(mfc_b), .busy(busy_b)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Memory model: read data is valid only in cycle 1+LATENCY of an access.
  always @(posedge CLK) begin
    #1;
    if (mem_en_a) since_a = 1;
    else if (since_a != 0) since_a++;
    if (force_en) rdata_a = force_val;
    else if (since_a == 3) begin
      rdata_a = mem_m[mem_addr_a];
      since_a = 0;
    end else rdata_a = 8'hEE;

    if (mem_en_b) since_b = 1;
    else if (since_b != 0) since_b++;
    if (since_b == 2) begin
      rdata_b = mem_m[mem_addr_b];
      since_b = 0;
    end else rdata_b = 8'hEE;
  end

  // Scoreboard monitor for the LATENCY=2 instance.
  always @(negedge CLK) begin : mon_a
    exp_t e;
    if (!reset) begin
      if (mem_en_a) begin
        if (q_a.size() == 0) checkOutput("a_en_unexpected", 1, 0);
        else begin
          e = q_a[0];
          checkOutput("a_addr", mem_addr_a, e.addr);
          checkOutput("a_we", mem_we_a, e.we);
          if (e.we) checkOutput("a_wdata", mem_wdata_a, e.wdata);
        end
        en_cyc_a = cyc;
      end
      if (mfc_a) begin
        if (q_a.size() == 0) checkOutput("a_mfc_unexpected", 1, 0);
        else begin
          e = q_a.pop_front();
          checkOutput("a_mbr", mbr_a, e.mbr);
          checkOutput("a_en_to_mfc", cyc - en_cyc_a, 3);
        end
      end
    end
  end

  // Scoreboard monitor for the LATENCY=1 instance.
  always @(negedge CLK) begin : mon_b
    exp_t e;
    if (!reset) begin
      if (mem_en_b) begin
        if (q_b.size() == 0) checkOutput("b_en_unexpected", 1, 0);
        else begin
          e = q_b[0];
          checkOutput("b_addr", mem_addr_b, e.addr);
          checkOutput("b_we", mem_we_b, e.we);
        end
        en_cyc_b = cyc;
      end
      if (mfc_b) begin
        if (q_b.size() == 0) checkOutput("b_mfc_unexpected", 1, 0);
        else begin
          e = q_b.pop_front();
          checkOutput("b_mbr", mbr_b, e.mbr);
          checkOutput("b_en_to_mfc", cyc - en_cyc_b, 2);
        end
      end
    end
  end

  task automatic stepCycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic driveIdle();
    mar_in = 1'b0; mbr_in = 1'b0; bus_in = 8'h00; wmfc_a = 1'b0; wmfc_b = 1'b0; rnw = 1'b0;
  endtask

  task automatic applyStimulus(input logic m_ld, input logic b_ld, input logic [7:0] bus,
                               input logic req, input logic rw);
    mar_in = m_ld; mbr_in = b_ld; bus_in = bus; wmfc_a = req; rnw = rw;
    stepCycle();
  endtask

  task automatic pushA(input logic [7:0] addr, input logic we, input logic [7:0] wdata,
                       input logic [7:0] mbr_exp);
    exp_t e;
    e.addr = addr; e.we = we; e.wdata = wdata; e.mbr = mbr_exp;
    q_a.push_back(e);
  endtask

  task automatic waitIdleA(input string tag);
    int n = 0;
    while (busy_a && n < 40) begin
      stepCycle();
      n++;
    end
    if (busy_a) checkOutput(tag, 1, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int mfc_mask;
    int en_count;
    logic saw_mfc;
    exp_t eb;

    for (int i = 0; i < 256; i++) mem_m[i] = 8'(i * 5 + 1);
    mem_m[8'h3C] = 8'hA5;
    mem_m[8'h10] = 8'hC3;
    mem_m[8'h20] = 8'h77;
    rdata_a = 8'hEE; rdata_b = 8'hEE;
    driveIdle();
    reset = 1'b1;
    mar_m = 8'h00; mbr_m = 8'h00;
    @(negedge CLK);
    stepCycle();
    stepCycle();
    reset = 1'b0;
    $display("[TB] reset values");
    checkOutput("rst_mem_addr", mem_addr_a, 0);
    checkOutput("rst_mem_wdata", mem_wdata_a, 0);
    checkOutput("rst_mbr", mbr_a, 0);
    checkOutput("rst_mem_en", mem_en_a, 0);
    checkOutput("rst_mem_we", mem_we_a, 0);
    checkOutput("rst_mfc", mfc_a, 0);
    checkOutput("rst_busy", busy_a, 0);

    $display("[TB] read at 0x3C");
    pushA(8'h3C, 1'b0, 8'h00, mem_m[8'h3C]);
    mar_m = 8'h3C; mbr_m = mem_m[8'h3C];
    applyStimulus(1'b1, 1'b0, 8'h3C, 1'b1, 1'b1);
    driveIdle();
    checkOutput("rd_c1_en", mem_en_a, 1);
    checkOutput("rd_c1_we", mem_we_a, 0);
    checkOutput("rd_c1_addr", mem_addr_a, 8'h3C);
    checkOutput("rd_c1_busy", busy_a, 1);
    stepCycle();
    checkOutput("rd_c2_busy", busy_a, 1);
    checkOutput("rd_c2_mfc", mfc_a, 0);
    stepCycle();
    checkOutput("rd_c3_busy", busy_a, 1);
    stepCycle();
    checkOutput("rd_c4_mfc", mfc_a, 1);
    checkOutput("rd_c4_mbr", mbr_a, 8'hA5);
    checkOutput("rd_c4_busy", busy_a, 1);
    stepCycle();
    checkOutput("rd_c5_busy", busy_a, 0);
    checkOutput("rd_c5_mfc", mfc_a, 0);

    $display("[TB] write 0x5A to 0x10");
    applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    mbr_m = 8'h5A;
    applyStimulus(1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    mar_m = 8'h10;
    pushA(mar_m, 1'b1, mbr_m, mbr_m);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    driveIdle();
    checkOutput("wr_c1_we", mem_we_a, 1);
    stepCycle();
    checkOutput("wr_c2_en", mem_en_a, 0);
    stepCycle();
    checkOutput("wr_c3_mfc", mfc_a, 0);
    stepCycle();
    checkOutput("wr_c4_mfc", mfc_a, 1);
    checkOutput("wr_c4_mbr", mbr_a, 8'h5A);
    stepCycle();
    checkOutput("wr_mbr_kept", mbr_a, 8'h5A);

    $display("[TB] MAR load while busy is dropped");
    pushA(mar_m, 1'b0, 8'h00, mem_m[mar_m]);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    driveIdle();
    stepCycle();
    applyStimulus(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    driveIdle();
    waitIdleA("busy_load_timeout");
    checkOutput("busy_mar_kept", mem_addr_a, 8'h10);
    pushA(mar_m, 1'b0, 8'h00, mem_m[mar_m]);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    driveIdle();
    waitIdleA("second_req_timeout");
    mbr_m = mem_m[mar_m];

    $display("[TB] held wmfc");
    pushA(mar_m, 1'b0, 8'h00, mem_m[mar_m]);
    pushA(mar_m, 1'b0, 8'h00, mem_m[mar_m]);
    mfc_mask = 0;
    en_count = 0;
    for (int i = 0; i < 14; i++) begin
      if (mfc_a) mfc_mask |= (1 << i);
      if (mem_en_a) en_count++;
      wmfc_a = (i < 10);
      rnw = 1'b1;
      stepCycle();
    end
    driveIdle();
    checkOutput("held_mfc_cycles", mfc_mask, (1 << 4) | (1 << 9));
    checkOutput("held_en_count", en_count, 2);
    checkOutput("held_queue_empty", q_a.size(), 0);

    $display("[TB] reset during read");
    pushA(8'h20, 1'b0, 8'h00, mem_m[8'h20]);
    applyStimulus(1'b1, 1'b0, 8'h20, 1'b1, 1'b1);
    driveIdle();
    stepCycle();
    force_en = 1'b1;
    force_val = 8'h77;
    reset = 1'b1;
    stepCycle();
    reset = 1'b0;
    force_en = 1'b0;
    q_a.delete();
    mar_m = 8'h00; mbr_m = 8'h00;
    checkOutput("abort_busy", busy_a, 0);
    checkOutput("abort_mfc", mfc_a, 0);
    checkOutput("abort_mbr", mbr_a, 0);
    checkOutput("abort_mem_addr", mem_addr_a, 0);
    saw_mfc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (mfc_a || busy_a) saw_mfc = 1'b1;
      stepCycle();
    end
    checkOutput("abort_no_mfc", saw_mfc, 0);

    $display("[TB] LATENCY=1 read");
    eb.addr = 8'h3C; eb.we = 1'b0; eb.wdata = 8'h00; eb.mbr = mem_m[8'h3C];
    q_b.push_back(eb);
    mar_in = 1'b1; bus_in = 8'h3C; wmfc_b = 1'b1; rnw = 1'b1;
    stepCycle();
    driveIdle();
    checkOutput("l1_c1_en", mem_en_b, 1);
    stepCycle();
    checkOutput("l1_c2_mfc", mfc_b, 0);
    stepCycle();
    checkOutput("l1_c3_mfc", mfc_b, 1);
    checkOutput("l1_c3_mbr", mbr_b, 8'hA5);
    stepCycle();
    checkOutput("l1_c4_busy", busy_b, 0);
    checkOutput("b_queue_empty", q_b.size(), 0);
    checkOutput("a_queue_empty", q_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
